// File: rtl/m_a_inv.sv
// m_a_inv - preimage search for a fixed 3-input, 2-output function f.
//
// A start request latches a target pair (z1,z2). The block then walks the
// candidate indices 000..111 and reports every index whose f() equals the
// target, or only the first one when EMIT_ALL = 0.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : asynchronous reset, active-high
//   start  : search request, honoured only in IDLE
//   z1, z2 : target pair, sampled when start is accepted
//   x1..x3 : reported preimage (x1 = MSB), held between reports
//   valid  : x1..x3 carry a fresh preimage this cycle
//   busy   : search in progress
//   done   : one-cycle completion pulse
//   count  : preimages found in the current or last search
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | evaluating candidate idx, one per clock
// DONE  | one-cycle completion, done asserted
module m_a_inv #(
    parameter bit EMIT_ALL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z1,
    input  logic       z2,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx;
    logic [1:0]  target;
    logic [2:0]  x_q;
    logic        valid_q;
    logic [1:0]  count_q;
    logic        match;

    // Forward function, indexed by {x1,x2,x3}; result is {z1,z2}.
    function automatic logic [1:0] f_fwd(input logic [2:0] i);
        logic [1:0] r;
        case (i)
            3'd0:    r = 2'b00;
            3'd1:    r = 2'b10;
            3'd2:    r = 2'b10;
            3'd3:    r = 2'b01;
            3'd4:    r = 2'b10;
            3'd5:    r = 2'b11;
            3'd6:    r = 2'b01;
            default: r = 2'b11;
        endcase
        return r;
    endfunction

    assign match = (f_fwd(idx) == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                // Last candidate (idx wraps to 0 on this edge) or early stop.
                if ((idx == 3'd7) || (!EMIT_ALL && match)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 3'd0;
            target  <= 2'b00;
            x_q     <= 3'd0;
            valid_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target  <= {z1, z2};
                        idx     <= 3'd0;
                        count_q <= 2'd0;
                    end
                end
                SCAN: begin
                    idx <= idx + 3'd1;
                    if (match) begin
                        x_q     <= idx;
                        valid_q <= 1'b1;
                        if (count_q != 2'd3) begin
                            count_q <= count_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x1    = x_q[2];
    assign x2    = x_q[1];
    assign x3    = x_q[0];
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: tb/tb_m_a_inv.sv
// Testbench for m_a_inv: one instance with EMIT_ALL=1 (a) and one with
// EMIT_ALL=0 (b) share all inputs. Expected reports are queued when a search
// is launched and popped as the cycles elapse.
module tb_m_a_inv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic z1 = 1'b0;
    logic z2 = 1'b0;

    logic       x1_a, x2_a, x3_a, valid_a, busy_a, done_a;
    logic [1:0] count_a;
    logic       x1_b, x2_b, x3_b, valid_b, busy_b, done_b;
    logic [1:0] count_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] x;
    } ev_t;

    ev_t        q[2][$];
    logic [2:0] exp_x[2];

    m_a_inv #(.EMIT_ALL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .z1(z1), .z2(z2),
        .x1(x1_a), .x2(x2_a), .x3(x3_a), .valid(valid_a),
        .busy(busy_a), .done(done_a), .count(count_a)
    );

    m_a_inv #(.EMIT_ALL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .z1(z1), .z2(z2),
        .x1(x1_b), .x2(x2_b), .x3(x3_b), .valid(valid_b),
        .busy(busy_b), .done(done_b), .count(count_b)
    );

    always #5 clk = ~clk;

    // Reference function written from the set listing of f.
    function automatic logic [1:0] f_ref(input int i);
        logic r1, r2;
        r1 = (i == 1) || (i == 2) || (i == 4) || (i == 5) || (i == 7);
        r2 = (i == 3) || (i == 5) || (i == 6) || (i == 7);
        return {r1, r2};
    endfunction

    // Launch a search from IDLE (called at a negedge) and check both
    // instances cycle by cycle until both are back in IDLE.
    task automatic run_search(input string nm, input logic t1, input logic t2,
                              input bit glitch);
        int         first;
        int         na;
        logic [2:0] ox;
        logic       ov, ob, od;
        logic [1:0] oc;
        int         last_done;
        bit         ev;
        q[0].delete();
        q[1].delete();
        first = -1;
        na    = 0;
        for (int k = 0; k < 8; k++) begin
            if (f_ref(k) == {t1, t2}) begin
                ev_t e;
                e.cyc = k + 1;
                e.x   = 3'(k);
                q[0].push_back(e);
                na++;
                if (first < 0) begin
                    first = k + 1;
                    q[1].push_back(e);
                end
            end
        end
        start = 1'b1;
        z1    = t1;
        z2    = t2;
        @(negedge clk);
        start = 1'b0;
        z1    = ~t1;
        z2    = ~t2;
        total++;
        if ({busy_a, busy_b} !== 2'b11) begin
            bad++;
            $display("FAIL %s busy_after_accept: got %b want 11", nm, {busy_a, busy_b});
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    ox = {x1_a, x2_a, x3_a}; ov = valid_a; ob = busy_a;
                    od = done_a; oc = count_a; last_done = 8;
                end else begin
                    ox = {x1_b, x2_b, x3_b}; ov = valid_b; ob = busy_b;
                    od = done_b; oc = count_b; last_done = first;
                end
                ev = (q[i].size() > 0) && (q[i][0].cyc == c);
                total++;
                if (ov !== ev) begin
                    bad++;
                    $display("FAIL %s inst%0d valid c=%0d: got %b want %b", nm, i, c, ov, ev);
                end
                if (ev) begin
                    exp_x[i] = q[i][0].x;
                    q[i].pop_front();
                end
                total++;
                if (ox !== exp_x[i]) begin
                    bad++;
                    $display("FAIL %s inst%0d x c=%0d: got %b want %b", nm, i, c, ox, exp_x[i]);
                end
                total++;
                if (od !== (c == last_done)) begin
                    bad++;
                    $display("FAIL %s inst%0d done c=%0d: got %b want %b", nm, i, c, od, (c == last_done));
                end
                total++;
                if (ob !== (c < last_done)) begin
                    bad++;
                    $display("FAIL %s inst%0d busy c=%0d: got %b want %b", nm, i, c, ob, (c < last_done));
                end
                if (c >= last_done) begin
                    total++;
                    if (oc !== ((i == 0) ? 2'(na) : 2'd1)) begin
                        bad++;
                        $display("FAIL %s inst%0d count c=%0d: got %0d want %0d", nm, i, c, oc,
                                 (i == 0) ? na : 1);
                    end
                end
            end
            if (glitch && c == 1) begin
                start = 1'b1;
                z1    = 1'b1;
                z2    = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        total++;
        if (q[0].size() + q[1].size() != 0) begin
            bad++;
            $display("FAIL %s unreported: got %0d left want 0", nm, q[0].size() + q[1].size());
        end
    endtask

    task automatic check_all_zero(input string nm);
        total++;
        if ({x1_a, x2_a, x3_a, valid_a, busy_a, done_a, count_a,
             x1_b, x2_b, x3_b, valid_b, busy_b, done_b, count_b} !== 16'd0) begin
            bad++;
            $display("FAIL %s outputs: got a=%b%b%b v%b b%b d%b c%0d b=%b%b%b v%b b%b d%b c%0d want all 0",
                     nm, x1_a, x2_a, x3_a, valid_a, busy_a, done_a, count_a,
                     x1_b, x2_b, x3_b, valid_b, busy_b, done_b, count_b);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        z1    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        start = 1'b0;
        rst   = 1'b0;
        exp_x[0] = 3'd0;
        exp_x[1] = 3'd0;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_target10();
        run_search("t10", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_target00();
        run_search("t00", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_target11();
        run_search("t11", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_target01();
        run_search("t01", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_search("ign", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        z1    = 1'b1;
        z2    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({valid_a, x1_a, x2_a, x3_a} !== 4'b1010) begin
            bad++;
            $display("FAIL rst_mid pre: got v%b x=%b%b%b want v1 x=010", valid_a, x1_a, x2_a, x3_a);
        end
        #1 rst = 1'b1;
        #1 check_all_zero("rst_mid_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("rst_mid_hold");
        end
        rst = 1'b0;
        exp_x[0] = 3'd0;
        exp_x[1] = 3'd0;
        @(negedge clk);
        check_all_zero("rst_mid_release");
        run_search("post_rst", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int t = 3; t >= 0; t--) begin
            logic [1:0] tt;
            tt = 2'(t);
            run_search("b2b", tt[1], tt[0], 1'b0);
        end
    endtask

    initial begin
        exp_x[0] = 3'd0;
        exp_x[1] = 3'd0;
        test_reset();
        test_target10();
        test_target00();
        test_target11();
        test_target01();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_a_inv.md
M_A_INV -- requirements
Module: m_a_inv

Interface
REQ-001 SHALL have parameter EMIT_ALL, default 1; 1 = report every preimage, 0 = stop at first preimage.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port start  input  1  request a preimage search; sampled on clk rising edge.
REQ-005 SHALL have ports z1, z2  input  1 each  target output pair, sampled only when start is accepted.
REQ-006 SHALL have ports x1, x2, x3  output  1 each  reported preimage; x1 is the MSB.
REQ-007 SHALL have port valid  output  1  x1..x3 carry a preimage this cycle.
REQ-008 SHALL have port busy  output  1  search in progress.
REQ-009 SHALL have port done  output  1  one-cycle search-complete pulse.
REQ-010 SHALL have port count  output  2  number of preimages found in the current or last search.

Function
REQ-011 SHALL embed forward function f over index x1x2x3: z1=1 for {001,010,100,101,111}; z2=1 for {011,101,110,111}; all other indices give 0.
REQ-012 SHALL implement FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-013 IDLE: busy=0; start=1 at edge E0 SHALL latch z1,z2 as target, clear idx and count to 0, and enter SCAN.
REQ-014 SCAN: busy=1; each edge E0+k+1 (k=0..7) SHALL evaluate candidate idx=k against the latched target, then increment idx.
REQ-015 On match at edge E0+k+1: x1..x3<=k, valid=1 for exactly the following cycle, count<=count+1.
REQ-016 On no match, valid SHALL be 0 the following cycle, and x1..x3 SHALL hold the last reported value.
REQ-017 EMIT_ALL=1: SCAN SHALL enter DONE at edge E0+8, after candidate 7, regardless of match.
REQ-018 EMIT_ALL=0: SCAN SHALL enter DONE at the edge of the first match, and remaining candidates SHALL NOT be evaluated.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then IDLE at the next edge.
REQ-020 done SHALL coincide with the valid pulse of the final candidate when that candidate matches.
REQ-021 start SHALL be ignored in SCAN and DONE.
REQ-022 z1,z2 changes SHALL be ignored after acceptance.
REQ-023 count SHALL be final when done=1 and SHALL hold until the next accepted start; max value 3, no wrap.
REQ-024 Every target pair has at least one preimage, so count>=1 at done.
REQ-025 idx SHALL be a 3-bit counter; its wrap 7->0 SHALL coincide with leaving SCAN.

Reset
REQ-026 rst=1 SHALL force state IDLE, x1..x3=000, valid=0, busy=0, done=0, count=0, and internal idx and target to 0, immediately and independent of clk.
REQ-027 rst asserted mid-SCAN SHALL abort the search with no done pulse.
REQ-028 After rst deasserts, the first start edge SHALL begin a normal search.
REQ-029 While rst=1, start SHALL be ignored.

Verification
REQ-030 EMIT_ALL=1, target z1z2=10, start at E0 -> valid with x=001 after E0+2, x=010 after E0+3, x=100 after E0+5; done after E0+8; count=3.
REQ-031 EMIT_ALL=1, target 00 -> single valid x=000 after E0+1; done after E0+8; count=1.
REQ-032 EMIT_ALL=1, target 11 -> valid x=101 after E0+6, valid x=111 after E0+8 coincident with done; count=2.
REQ-033 EMIT_ALL=0, target 01 -> single valid x=011 after E0+4 coincident with done; count=1; busy low from the next cycle.
REQ-034 Target 01 accepted, then start=1 and z1z2=10 at E0+2 -> ignored; reported x=011,110; count=2.
REQ-035 rst pulsed after E0+3 during target-10 search -> all outputs 0 immediately, no done; a new start with target 00 -> x=000 reported, count=1.
